// File: rtl/pcw_input_pkg.sv
// pcw_input_pkg: shared types and widths for the input-conditioning blocks
package pcw_input_pkg;
  localparam int GLITCH_W = 8;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {LOW, QUAL_HI, HIGH, QUAL_LO} debounce_state_t;
endpackage

// File: rtl/signal_debounce_sync_chain.sv
// sync_chain: STAGES-deep flop chain bringing an asynchronous level into clk_sys
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain_q;
  // shift the raw level through the chain; the oldest stage is the safe output
  always_ff @(posedge clk_sys) begin
    if (!reset_n) chain_q <= '0;
    else chain_q <= {chain_q[STAGES-2:0], d};
  end
  assign q = chain_q[STAGES-1];
endmodule

// File: rtl/signal_debounce.sv
// signal_debounce: synchronise, qualify and edge-detect a noisy input.
// Define SIGNAL_DEBOUNCE_EDGE_EN to generate pos_edge/neg_edge pulses;
// without it both pulse ports are tied to 0.
module signal_debounce
  import pcw_input_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                signal_in,
  input  logic                glitch_clr,
  output logic                level_out,
  output logic                pos_edge,
  output logic                neg_edge,
  output logic [GLITCH_W-1:0] glitch_cnt
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic s_sync;
  debounce_state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic level_q;
  logic glitch_hit;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .d      (signal_in),
    .q      (s_sync)
  );
  // qualification FSM; level follows the stable state so qualifying never disturbs it
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      case (state_q)
        LOW: if (s_sync) begin
          state_q <= QUAL_HI;
          cnt_q   <= '0;
        end
        QUAL_HI: if (!s_sync) state_q <= LOW;
          else if (cnt_q == LAST) begin
            state_q <= HIGH;
            level_q <= 1'b1;
          end else cnt_q <= cnt_q + 1'b1;
        HIGH: if (!s_sync) begin
          state_q <= QUAL_LO;
          cnt_q   <= '0;
        end
        QUAL_LO: if (s_sync) state_q <= HIGH;
          else if (cnt_q == LAST) begin
            state_q <= LOW;
            level_q <= 1'b0;
          end else cnt_q <= cnt_q + 1'b1;
        default: state_q <= LOW;
      endcase
    end
  end
  // a qualification abandoned before completion is a rejected glitch; clear wins
  always_comb begin
    glitch_hit = (state_q == QUAL_HI && !s_sync) || (state_q == QUAL_LO && s_sync);
    glitch_d = glitch_clr ? '0 : (glitch_hit && glitch_q != '1) ? glitch_q + 1'b1 : glitch_q;
  end
  // saturating rejected-transition counter
  always_ff @(posedge clk_sys) begin
    if (!reset_n) glitch_q <= '0;
    else glitch_q <= glitch_d;
  end
  assign level_out  = level_q;
  assign glitch_cnt = glitch_q;
`ifdef SIGNAL_DEBOUNCE_EDGE_EN
  logic pos_q, neg_q;
  // pulse on the same edge the qualified level changes
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      pos_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      pos_q <= state_q == QUAL_HI && s_sync && cnt_q == LAST;
      neg_q <= state_q == QUAL_LO && !s_sync && cnt_q == LAST;
    end
  end
  assign pos_edge = pos_q;
  assign neg_edge = neg_q;
`else
  assign pos_edge = 1'b0;
  assign neg_edge = 1'b0;
`endif
endmodule

// File: tb/tb_signal_debounce.sv
// tb_signal_debounce: directed vector bench for signal_debounce (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
module tb_signal_debounce;
`ifdef SIGNAL_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif
  typedef struct {
    bit sig;
    bit clr;
    bit lvl;
    bit pe;
    bit ne;
    int gc;
  } vec_t;
  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic signal_in = 1'b0;
  logic glitch_clr = 1'b0;
  logic level_out, pos_edge, neg_edge;
  logic [7:0] glitch_cnt;
  int checks = 0;
  int failures = 0;
  vec_t vecs[$];
  signal_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .signal_in (signal_in),
    .glitch_clr(glitch_clr),
    .level_out (level_out),
    .pos_edge  (pos_edge),
    .neg_edge  (neg_edge),
    .glitch_cnt(glitch_cnt)
  );
  always #5 clk_sys = ~clk_sys;
  task automatic step(input bit s, input bit c);
    signal_in = s;
    glitch_clr = c;
    @(posedge clk_sys);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input bit lvl, input bit pe, input bit ne, input int gc);
    chk({tag, " level_out"}, int'(level_out), int'(lvl));
    chk({tag, " pos_edge"}, int'(pos_edge), int'(pe & EDGE_EN));
    chk({tag, " neg_edge"}, int'(neg_edge), int'(ne & EDGE_EN));
    chk({tag, " glitch_cnt"}, int'(glitch_cnt), gc);
    chk({tag, " edges_exclusive"}, int'(pos_edge & neg_edge), 0);
  endtask
  function automatic void add(input bit s, input bit c, input bit l, input bit p, input bit n, input int g);
    vec_t v;
    v.sig = s; v.clr = c; v.lvl = l; v.pe = p; v.ne = n; v.gc = g;
    vecs.push_back(v);
  endfunction
  initial begin
    for (int k = 0; k < 9; k++) add(1'b1, 1'b0, k >= 6, k == 6, 1'b0, 0);
    for (int k = 0; k < 9; k++) add(1'b0, 1'b0, k < 6, 1'b0, k == 6, 0);
    for (int k = 0; k < 6; k++) add(k < 2, 1'b0, 1'b0, 1'b0, 1'b0, k >= 4 ? 1 : 0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
    chk_all("reset", 1'b0, 1'b0, 1'b0, 0);
    reset_n = 1'b1;
    foreach (vecs[i]) begin
      step(vecs[i].sig, vecs[i].clr);
      chk_all($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].pe, vecs[i].ne, vecs[i].gc);
    end
    for (int g = 0; g < 300; g++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
    end
    chk_all("storm_saturated", 1'b0, 1'b0, 1'b0, 255);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("storm_hold glitch_cnt", int'(glitch_cnt), 255);
    step(1'b0, 1'b1);
    chk_all("clr_beats_inc", 1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("glitch_after_clr glitch_cnt", int'(glitch_cnt), 1);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
    reset_n = 1'b0;
    step(1'b1, 1'b0);
    chk_all("midqual_reset", 1'b0, 1'b0, 1'b0, 0);
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0);
      chk_all($sformatf("post_reset%0d", k), k >= 6, k == 6, 1'b0, 0);
    end
    step(1'b0, 1'b0);
    for (int k = 1; k < 5; k++) begin
      step(1'b1, 1'b0);
      chk_all($sformatf("high_glitch%0d", k), 1'b1, 1'b0, 1'b0, k >= 3 ? 1 : 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/signal_debounce.md
SIGNAL_DEBOUNCE -- requirements
Module: signal_debounce

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchroniser flops (minimum 2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000, number of consecutive stable cycles required to accept a new level (1..65535).
REQ-003 SHALL have port clk_sys  input  1  system clock; the only clock, all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port signal_in  input  1  asynchronous raw input (key, joystick line, switch).
REQ-006 SHALL have port glitch_clr  input  1  synchronous clear of glitch_cnt.
REQ-007 SHALL have port level_out  output  1  debounced level, registered.
REQ-008 SHALL have port pos_edge  output  1  one-cycle pulse when level_out rises.
REQ-009 SHALL have port neg_edge  output  1  one-cycle pulse when level_out falls.
REQ-010 SHALL have port glitch_cnt  output  8  count of rejected transitions, saturating.

Function
REQ-011 SHALL pass signal_in through a SYNC_STAGES-deep flop chain; s_sync is the last stage, and no other logic reads signal_in.
REQ-012 SHALL implement states LOW, QUAL_HI, HIGH, QUAL_LO, with a 16-bit counter cnt.
REQ-013 SHALL, in LOW with s_sync=1, move to QUAL_HI with cnt=0; in HIGH with s_sync=0, move to QUAL_LO with cnt=0.
REQ-014 SHALL, in QUAL_HI with s_sync=1, move to HIGH when cnt==DEBOUNCE_CYCLES-1 and otherwise increment cnt; QUAL_LO mirrors this toward LOW.
REQ-015 SHALL, in QUAL_HI with s_sync=0 (or QUAL_LO with s_sync=1), return to the previous stable state and increment glitch_cnt.
REQ-016 SHALL saturate glitch_cnt at 255.
REQ-017 SHALL give glitch_clr priority over a same-cycle increment (result 0).
REQ-018 SHALL make level_out 1 exactly in state HIGH and QUAL_LO, so qualification does not disturb the output.
REQ-019 SHALL assert pos_edge on the same edge that level_out rises (HIGH entered from QUAL_HI), and neg_edge likewise on falling, each exactly one cycle wide; both are never high together.
REQ-020 SHALL provide latency such that, counting the first edge sampling a stable new input as edge 0, level_out changes on edge SYNC_STAGES+DEBOUNCE_CYCLES.
REQ-021 SHALL require no reload beyond REQ-013 for back-to-back accepted transitions; the minimum accepted period is 2*(DEBOUNCE_CYCLES+1) cycles.

Reset
REQ-022 SHALL, while reset_n=0 at a clock edge, clear the sync chain, cnt, glitch_cnt, level_out, pos_edge and neg_edge to 0 and set state LOW.
REQ-023 SHALL, for an input held high through reset, raise level_out with one pos_edge on edge SYNC_STAGES+DEBOUNCE_CYCLES after reset_n rises (edge 0 = first edge with reset_n=1).
REQ-024 SHALL treat reset mid-qualification as abandoning the qualification with no pulse and no glitch count.

Configuration
REQ-025 SHALL, with macro SIGNAL_DEBOUNCE_EDGE_EN defined, drive pos_edge/neg_edge per REQ-019.
REQ-026 SHALL, without SIGNAL_DEBOUNCE_EDGE_EN, keep the ports present, tie them constant 0 and synthesise no edge logic; all other behaviour is unchanged.

Structure
REQ-027 SHALL place the state enum typedef (debounce_state_t), GLITCH_W=8 and CNT_W=16 in shared package pcw_input_pkg.
REQ-028 SHALL implement the synchroniser as sub-module sync_chain (parameter STAGES, ports clk_sys, reset_n, d, q).

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, macro defined unless stated)
REQ-029 Stimulus: signal_in 0->1 sampled at edge 0, held. Required response: level_out=1 and pos_edge=1 at edge 6, pos_edge=0 at edge 7, glitch_cnt=0.
REQ-030 Stimulus: from LOW, a 2-cycle high pulse on signal_in. Required response: level_out and pos_edge stay 0, glitch_cnt=1.
REQ-031 Stimulus: 300 rejected glitches, then glitch_clr asserted on the same cycle as another glitch. Required response: glitch_cnt holds at 255, then becomes 0.
REQ-032 Stimulus: from HIGH, signal_in held 0. Required response: neg_edge for one cycle at edge 6 with level_out=0; level_out stays 1 during qualification.
REQ-033 Stimulus: reset_n=0 for one edge at cnt=2 in QUAL_HI, signal_in still high. Required response: all outputs 0 after that edge, then level_out=1 at edge 6 after release.
REQ-034 Stimulus: macro undefined, repeat REQ-029. Required response: level_out timing identical; pos_edge and neg_edge constantly 0.
